// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_t   : controller states (IDLE -> SHIFT -> DONE -> IDLE)
//   cnt_width : width of the bit counter, wide enough to hold WIDTH itself
package serial_sub_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/fs_cell.sv
// Combinational 1-bit full subtractor: d = a - b - bin, bo = borrow-out.
// Ports:
//   a, b, bin : input bits (minuend, subtrahend, borrow-in)
//   d         : difference bit
//   bo        : borrow-out
module fs_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bo
);

  always_comb begin
    d  = a ^ b ^ bin;
    // Borrow when b alone exceeds a, or when a==b and a borrow is pending.
    bo = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b - bin, one bit per clock,
// LSB first, using a single fs_cell plus a borrow flop.
// Ports:
//   clk, rst            : clock (rising edge), synchronous active-high reset
//   in_valid / in_ready : operand handshake (in_ready only in IDLE)
//   a, b, bin           : minuend, subtrahend, initial borrow-in
//   out_valid/out_ready : result handshake (out_valid only in DONE)
//   diff, bout          : result modulo 2^WIDTH and final borrow-out
//   zero, ovf           : present only when SERIAL_SUB_FLAGS_EN is defined;
//                         diff==0 and signed overflow, valid with out_valid
// An accept at edge N gives out_valid after edge N+WIDTH+1: WIDTH shift
// cycles followed by one cycle that publishes the result to the outputs.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_FLAGS_EN
  ,
  output logic             zero,
  output logic             ovf
`endif
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);

  state_t state, nstate;

  logic [CNT_W-1:0] cnt;
  logic             brw;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] res_sr;
  logic             cell_d;
  logic             cell_bo;
  logic             accept;
  logic             last;

`ifdef SERIAL_SUB_FLAGS_EN
  // Operand MSBs are captured at accept because the shift regs consume them.
  logic             a_msb;
  logic             b_msb;
`endif

  assign accept = (state == S_IDLE) && in_valid;
  assign last   = (cnt == LAST_CNT);

  fs_cell u_cell (
    .a   (sh_a[0]),
    .b   (sh_b[0]),
    .bin (brw),
    .d   (cell_d),
    .bo  (cell_bo)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nstate;
  end

  // Next-state logic
  always_comb begin
    nstate = state;
    unique case (state)
      S_IDLE:  if (in_valid)  nstate = S_SHIFT;
      S_SHIFT: if (last)      nstate = S_DONE;
      S_DONE:  if (out_ready) nstate = S_IDLE;
      default:                nstate = S_IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
  end

  // Control state: borrow flop, bit counter and published result
  always_ff @(posedge clk) begin
    if (rst) begin
      brw  <= 1'b0;
      cnt  <= '0;
      diff <= '0;
      bout <= 1'b0;
`ifdef SERIAL_SUB_FLAGS_EN
      zero <= 1'b0;
      ovf  <= 1'b0;
`endif
    end else if (accept) begin
      brw <= bin;
      cnt <= '0;
    end else if (state == S_SHIFT) begin
      if (last) begin
        // Outputs move only here, so they hold the previous result meanwhile.
        diff <= res_sr;
        bout <= brw;
`ifdef SERIAL_SUB_FLAGS_EN
        zero <= (res_sr == '0);
        ovf  <= (a_msb ^ b_msb) & (a_msb ^ res_sr[WIDTH-1]);
`endif
      end else begin
        brw <= cell_bo;
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Operand and result shift registers (no reset: contents are qualified by state)
  always_ff @(posedge clk) begin
    if (accept) begin
      sh_a <= a;
      sh_b <= b;
`ifdef SERIAL_SUB_FLAGS_EN
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
`endif
    end else if ((state == S_SHIFT) && !last) begin
      sh_a   <= {1'b0, sh_a[WIDTH-1:1]};
      sh_b   <= {1'b0, sh_b[WIDTH-1:1]};
      // LSB-first: after WIDTH shifts the first bit lands in res_sr[0].
      res_sr <= {cell_d, res_sr[WIDTH-1:1]};
    end
  end

endmodule
